// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, DBIT data bits LSB-first, optional parity, stop interval.
// All outputs registered; tx falls on the accept edge; requests while busy are dropped, never queued.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int S_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = $clog2(DBIT);

    localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);
    localparam logic          ODD         = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shift;
    logic            par;

    // tx is registered, so each transition loads the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            s            <= '0;
            n            <= '0;
            shift        <= '0;
            par          <= 1'b0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (tx_start) begin
                        shift   <= din;
                        par     <= (^din) ^ ODD;
                        s       <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                            tx    <= shift[0];
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            shift <= shift >> 1;
                            if (n == N_LAST) begin
                                if (PARITY_EN != 0) begin
                                    state <= PARITY;
                                    tx    <= par;
                                end else begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end
                            end else begin
                                n  <= n + 1'b1;
                                tx <= shift[1];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP_LAST) begin
                            s            <= '0;
                            state        <= IDLE;
                            tx_busy      <= 1'b0;
                            tx_done_tick <= 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
